div4x2_vector_seq: RTL and testbench

- Bit-sliced sequential restoring divider; the inverse of the mul4 vector multiplier individuals.
- Each of LANES bit positions is an independent test case. The dividend is a 4-bit value {n3,n2,n1,n0}. The divisor is a 2-bit value {d1,d0}.
- Produces a 4-bit quotient and 2-bit remainder per lane, one quotient bit per cycle.
- Used by the evaluation harness to invert multiplier candidate outputs and cross-check products.

---
 rtl/div4x2_vector_seq.sv | 170 +++++++++++++++++
 tb/tb_div4x2_vector_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div4x2_vector_seq.sv
`default_nettype none
// ============================================================================
// Module   : div4x2_vector_seq
// Purpose  : Bit-sliced sequential restoring divider. Every bit position is an
//            independent lane dividing a 4-bit dividend {n3,n2,n1,n0} by a
//            2-bit divisor {d1,d0}. One quotient bit is resolved per cycle,
//            MSB first, so an operation takes four iteration cycles.
// Ports    : clk, rst            clock / synchronous active-high reset
//            in_valid, in_ready  operand handshake
//            n3..n0, d1, d0      dividend / divisor bits per lane
//            out_valid,out_ready result handshake
//            q3..q0, r1, r0, dz  quotient, remainder, divide-by-zero per lane
// Revision : 1.0  initial release
// ============================================================================
module div4x2_vector_seq #(
  parameter int LANES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] n3,
  input  logic [LANES-1:0] n2,
  input  logic [LANES-1:0] n1,
  input  logic [LANES-1:0] n0,
  input  logic [LANES-1:0] d1,
  input  logic [LANES-1:0] d0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] q3,
  output logic [LANES-1:0] q2,
  output logic [LANES-1:0] q1,
  output logic [LANES-1:0] q0,
  output logic [LANES-1:0] r1,
  output logic [LANES-1:0] r0,
  output logic [LANES-1:0] dz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Captured operands; n_q[k] holds dividend bit k of every lane.
  logic [3:0][LANES-1:0] n_q;
  logic [LANES-1:0]      d1_q, d0_q;

  // Per-lane partial remainder and quotient bits resolved so far.
  logic [LANES-1:0][2:0] rem_q, rem_d;
  logic [LANES-1:0][3:0] qw_q, qw_d;
  logic [1:0]            k_q;

  // Result registers, loaded on the last iteration and held afterwards.
  logic [LANES-1:0] q3_q, q2_q, q1_q, q0_q, r1_q, r0_q, dz_q;

  // Per-lane combinational iteration results.
  logic [LANES-1:0][2:0] sh_d;
  logic [LANES-1:0]      ge_d;
  logic [LANES-1:0]      q3_d, q2_d, q1_d, q0_d, r1_d, r0_d;

  // One restoring step per lane. A zero divisor always compares as "fits"
  // and subtracts nothing, so such lanes naturally yield q=1111 and keep
  // the last two shifted-in dividend bits (n1:n0) as remainder.
  always_comb begin
    sh_d = '0;
    ge_d = '0;
    rem_d = rem_q;
    qw_d = qw_q;
    q3_d = '0;
    q2_d = '0;
    q1_d = '0;
    q0_d = '0;
    r1_d = '0;
    r0_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sh_d[i]  = {rem_q[i][1:0], n_q[k_q][i]};
      ge_d[i]  = (sh_d[i] >= {1'b0, d1_q[i], d0_q[i]});
      rem_d[i] = ge_d[i] ? (sh_d[i] - {1'b0, d1_q[i], d0_q[i]}) : sh_d[i];
      qw_d[i]  = {qw_q[i][2:0], ge_d[i]};
      q3_d[i]  = qw_d[i][3];
      q2_d[i]  = qw_d[i][2];
      q1_d[i]  = qw_d[i][1];
      q0_d[i]  = qw_d[i][0];
      r1_d[i]  = rem_d[i][1];
      r0_d[i]  = rem_d[i][0];
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_d = S_RUN;
      end
      S_RUN: begin
        if (k_q == 2'd0) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      d1_q    <= '0;
      d0_q    <= '0;
      rem_q   <= '0;
      qw_q    <= '0;
      k_q     <= '0;
      q3_q    <= '0;
      q2_q    <= '0;
      q1_q    <= '0;
      q0_q    <= '0;
      r1_q    <= '0;
      r0_q    <= '0;
      dz_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            n_q   <= {n3, n2, n1, n0};
            d1_q  <= d1;
            d0_q  <= d0;
            rem_q <= '0;
            qw_q  <= '0;
            k_q   <= 2'd3;
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          qw_q  <= qw_d;
          k_q   <= k_q - 2'd1;
          if (k_q == 2'd0) begin
            q3_q <= q3_d;
            q2_q <= q2_d;
            q1_q <= q1_d;
            q0_q <= q0_d;
            r1_q <= r1_d;
            r0_q <= r0_d;
            dz_q <= ~(d1_q | d0_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign q3 = q3_q;
  assign q2 = q2_q;
  assign q1 = q1_q;
  assign q0 = q0_q;
  assign r1 = r1_q;
  assign r0 = r0_q;
  assign dz = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_div4x2_vector_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div4x2_vector_seq
// Purpose  : Self-checking bench for div4x2_vector_seq. A vector table holds
//            operands with expected results; a scoreboard queue receives the
//            expected record at each accept and is compared at each result
//            handshake. Hand-written sequences cover backpressure, reset
//            mid-operation and back-to-back throughput.
// Revision : 1.0  initial release
// ============================================================================
module tb_div4x2_vector_seq;

  localparam int LANES = 16;

  typedef struct {
    logic [15:0] n3, n2, n1, n0, d1, d0;
    logic [15:0] q3, q2, q1, q0, r1, r0, dz;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] n3, n2, n1, n0, d1, d0;
  logic [15:0] q3, q2, q1, q0, r1, r0, dz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;
  int n_done = 0;
  int acc_cyc = 0;
  bit ov_seen = 1'b0;
  int acc_hist[$];
  vec_t sb_q[$];
  vec_t cur_exp;
  vec_t tbl[6];

  div4x2_vector_seq #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .n3(n3), .n2(n2), .n1(n1), .n0(n0), .d1(d1), .d0(d0),
    .out_valid(out_valid), .out_ready(out_ready),
    .q3(q3), .q2(q2), .q1(q1), .q0(q0), .r1(r1), .r0(r0), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a3, a2, a1, a0, b1, b0,
                              input logic [15:0] e3, e2, e1, e0, f1, f0, z);
    vec_t v;
    v.n3 = a3; v.n2 = a2; v.n1 = a1; v.n0 = a0; v.d1 = b1; v.d0 = b0;
    v.q3 = e3; v.q2 = e2; v.q1 = e1; v.q0 = e0; v.r1 = f1; v.r0 = f0; v.dz = z;
    return v;
  endfunction

  // Reference: ordinary integer division per lane.
  function automatic vec_t model(input logic [15:0] a3, a2, a1, a0, b1, b0);
    vec_t v;
    logic [3:0] nv, dv, qv, rv;
    v = mk(a3, a2, a1, a0, b1, b0, '0, '0, '0, '0, '0, '0, '0);
    for (int i = 0; i < LANES; i++) begin
      nv = {a3[i], a2[i], a1[i], a0[i]};
      dv = {2'b00, b1[i], b0[i]};
      if (dv == 4'd0) begin
        qv = 4'hF;
        rv = {2'b00, nv[1:0]};
        v.dz[i] = 1'b1;
      end else begin
        qv = nv / dv;
        rv = nv % dv;
      end
      v.q3[i] = qv[3]; v.q2[i] = qv[2]; v.q1[i] = qv[1]; v.q0[i] = qv[0];
      v.r1[i] = rv[1]; v.r0[i] = rv[0];
    end
    return v;
  endfunction

  // Scoreboard: push on accept, pop and compare on result handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      ov_seen = 1'b0;
    end else begin
      if (out_valid && !ov_seen) begin
        ov_seen = 1'b1;
        check("latency", 128'(cyc - acc_cyc), 128'(5));
      end
      if (out_valid && out_ready) begin
        vec_t e;
        ov_seen = 1'b0;
        n_done++;
        if (sb_q.size() == 0) begin
          check("unexpected_result", 128'(1), 128'(0));
        end else begin
          e = sb_q.pop_front();
          check("q3", 128'(q3), 128'(e.q3));
          check("q2", 128'(q2), 128'(e.q2));
          check("q1", 128'(q1), 128'(e.q1));
          check("q0", 128'(q0), 128'(e.q0));
          check("r1", 128'(r1), 128'(e.r1));
          check("r0", 128'(r0), 128'(e.r0));
          check("dz", 128'(dz), 128'(e.dz));
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(cur_exp);
        acc_cyc = cyc;
        acc_hist.push_back(cyc);
        n_acc++;
      end
    end
  end

  task automatic drive(input vec_t v);
    n3 = v.n3; n2 = v.n2; n1 = v.n1; n0 = v.n0; d1 = v.d1; d0 = v.d0;
    cur_exp = v;
  endtask

  task automatic issue(input vec_t v);
    bit got;
    @(posedge clk); #1;
    drive(v);
    in_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) check("accept_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int c = 0; c < 40 && n_done < target; c++) @(negedge clk);
    @(negedge clk);
    check("result_count", 128'(n_done), 128'(target));
  endtask

  initial begin
    int a0, done_base, idx;
    logic [111:0] exp_out;

    // Lane i of the ramp dividend holds the value i.
    tbl[0] = mk(16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 16'hFFFF, 16'hFFFF,
                16'h0000, 16'hF000, 16'h0FC0, 16'h8E38, 16'h4924, 16'h2492, 16'h0000);
    tbl[1] = mk(16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 16'h0000, 16'h0000,
                16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hCCCC, 16'hAAAA, 16'hFFFF);
    tbl[2] = mk(16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 16'hFFFF, 16'h0000,
                16'h0000, 16'hFF00, 16'hF0F0, 16'hCCCC, 16'h0000, 16'hAAAA, 16'h0000);
    tbl[3] = mk(16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 16'h0000, 16'hFFFF,
                16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000);
    // Lanes 0-3 d=0, 4-7 d=1, 8-11 d=2, 12-15 d=3.
    tbl[4] = model(16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 16'hFF00, 16'hF0F0);
    tbl[5] = model(16'h5A3C, 16'hC3A5, 16'h96E1, 16'h1E7B, 16'hFF00, 16'hF0F0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    n3 = '0; n2 = '0; n1 = '0; n0 = '0; d1 = '0; d0 = '0;
    cur_exp = tbl[0];
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(0));
    check("reset_outputs", 128'({q3, q2, q1, q0, r1, r0, dz}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'(1));

    // Table-driven operations.
    for (int t = 0; t < 5; t++) begin
      issue(tbl[t]);
      wait_done(n_done + 1);
    end

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(tbl[0]);
    for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
    a0 = n_acc;
    exp_out = {tbl[0].q3, tbl[0].q2, tbl[0].q1, tbl[0].q0, tbl[0].r1, tbl[0].r0, tbl[0].dz};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      n3 = ~n3; n2 = ~n2; n1 = ~n1; n0 = ~n0; d1 = ~d1;
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_hold", 128'({q3, q2, q1, q0, r1, r0, dz}), 128'(exp_out));
    end
    check("bp_no_accept", 128'(n_acc), 128'(a0));
    done_base = n_done;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_one_handshake", 128'(n_done), 128'(done_base + 1));
    check("bp_idle_in_ready", 128'(in_ready), 128'(1));
    check("bp_idle_out_valid", 128'(out_valid), 128'(0));
    check("bp_keep_outputs", 128'({q3, q2, q1, q0, r1, r0, dz}), 128'(exp_out));

    // Reset after the second RUN edge; the operation must vanish.
    issue(tbl[1]);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_outputs", 128'({q3, q2, q1, q0, r1, r0, dz}), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    done_base = n_done;
    repeat (6) @(negedge clk);
    check("rst_no_result", 128'(n_done), 128'(done_base));
    issue(tbl[0]);
    wait_done(n_done + 1);

    // Back-to-back: in_valid and out_ready held high across three operations.
    done_base = n_done;
    a0 = acc_hist.size();
    @(posedge clk); #1;
    drive(tbl[4]);
    in_valid = 1'b1;
    idx = 1;
    for (int c = 0; c < 60 && in_valid; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        @(posedge clk); #1;
        if (idx == 1) drive(tbl[5]);
        else if (idx == 2) drive(tbl[1]);
        else in_valid = 1'b0;
        idx++;
      end
    end
    wait_done(done_base + 3);
    if (acc_hist.size() >= a0 + 3) begin
      check("b2b_gap1", 128'(acc_hist[a0 + 1] - acc_hist[a0]), 128'(6));
      check("b2b_gap2", 128'(acc_hist[a0 + 2] - acc_hist[a0 + 1]), 128'(6));
    end else begin
      check("b2b_accepts", 128'(acc_hist.size() - a0), 128'(3));
    end
    check("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
